// File: rtl/mat_write_buffer.sv
// mat_write_buffer: in-order write FIFO between matrixProcessor and the shared
// memory bus. Write strobes are captured without back-pressure, drained with a
// valid/ready handshake, and pending addresses are checked for read-after-write
// hazards.
module mat_write_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_wr_en,
  input  logic [WIDTH-1:0]         in_wr_addr,
  input  logic [WIDTH-1:0]         in_wr_data,
  input  logic [WIDTH-1:0]         hazard_addr,
  output logic                     hazard_hit,
  output logic                     mem_valid,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_data,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] entry_addr_q [DEPTH];
  logic [WIDTH-1:0] entry_addr_d [DEPTH];
  logic [WIDTH-1:0] entry_data_q [DEPTH];
  logic [WIDTH-1:0] entry_data_d [DEPTH];

  logic             pop;
  logic             push;
  logic             drop;
  logic [PW-1:0]    slot;

  // Status decode straight from the registered count; the head entry is read
  // combinationally so a pushed entry appears one cycle after its strobe.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    mem_valid = !empty;
    mem_addr  = entry_addr_q[rd_ptr_q];
    mem_data  = entry_data_q[rd_ptr_q];
    count     = count_q;
    overflow  = overflow_q;
  end

  // Handshake and next-state: a push is allowed when full only if the head
  // leaves in the same cycle; otherwise the write is dropped and flagged.
  always_comb begin
    pop          = mem_valid && mem_ready;
    push         = in_wr_en && (!full || pop);
    drop         = in_wr_en && full && !pop;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    overflow_d   = overflow_q;
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      entry_addr_d[wr_ptr_q] = in_wr_addr;
      entry_data_d[wr_ptr_q] = in_wr_data;
      wr_ptr_d               = wr_ptr_q + 1'b1;
    end
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Hazard check walks occupied slots starting at the read pointer so stale
  // storage in freed slots never matches, including across pointer wrap.
  always_comb begin
    hazard_hit = 1'b0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (entry_addr_q[slot] == hazard_addr)) begin
        hazard_hit = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset discarding pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are meaningless outside the occupied window, so
  // it needs no reset.
  always_ff @(posedge clk) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

endmodule

// File: tb/tb_mat_write_buffer.sv
// Directed testbench for mat_write_buffer with DEPTH=4, WIDTH=32.
module tb_mat_write_buffer;

  logic        clk;
  logic        rst;
  logic        in_wr_en;
  logic [31:0] in_wr_addr;
  logic [31:0] in_wr_data;
  logic [31:0] hazard_addr;
  logic        hazard_hit;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        clear_overflow;

  int checks;
  int errors;

  mat_write_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_wr_en       (in_wr_en),
    .in_wr_addr     (in_wr_addr),
    .in_wr_data     (in_wr_data),
    .hazard_addr    (hazard_addr),
    .hazard_hit     (hazard_hit),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr_en, input logic [31:0] addr,
                               input logic [31:0] data, input logic ready);
    in_wr_en   = wr_en;
    in_wr_addr = addr;
    in_wr_data = data;
    mem_ready  = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence covering reset, latency, overflow, wrap and hazards.
  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    in_wr_en       = 1'b0;
    in_wr_addr     = '0;
    in_wr_data     = '0;
    hazard_addr    = '0;
    mem_ready      = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset and idle");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, i[0]);
      tick();
      checkOutput("idle_count", 32'(count), 32'd0);
      checkOutput("idle_empty", 32'(empty), 32'd1);
      checkOutput("idle_valid", 32'(mem_valid), 32'd0);
      checkOutput("idle_ovf", 32'(overflow), 32'd0);
      checkOutput("idle_hazard", 32'(hazard_hit), 32'd0);
    end

    $display("[TB] single push with ready high");
    applyStimulus(1'b1, 32'h100, 32'hAAAA0001, 1'b1);
    checkOutput("no_bypass_valid", 32'(mem_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("single_valid", 32'(mem_valid), 32'd1);
    checkOutput("single_addr", mem_addr, 32'h100);
    checkOutput("single_data", mem_data, 32'hAAAA0001);
    checkOutput("single_count", 32'(count), 32'd1);
    tick();
    checkOutput("single_empty", 32'(empty), 32'd1);
    checkOutput("single_valid_off", 32'(mem_valid), 32'd0);

    $display("[TB] fill, drop, drain");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h10 + 32'(4 * i), 32'hD000 + 32'(i), 1'b0);
      tick();
      checkOutput("fill_count", 32'(count), 32'(i + 1));
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 32'h20, 32'hDEAD, 1'b0);
    tick();
    checkOutput("drop_ovf", 32'(overflow), 32'd1);
    checkOutput("drop_count", 32'(count), 32'd4);
    checkOutput("drop_head_stable", mem_addr, 32'h10);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_valid", 32'(mem_valid), 32'd1);
      checkOutput("drain_addr", mem_addr, 32'h10 + 32'(4 * i));
      checkOutput("drain_data", mem_data, 32'hD000 + 32'(i));
      tick();
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_ovf_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checkOutput("clear_ovf", 32'(overflow), 32'd0);

    $display("[TB] full-rate streaming through wrap");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * (i + 4)), 32'hB000_0000 + 32'(i + 4), 1'b1);
      checkOutput("stream_count", 32'(count), 32'd4);
      checkOutput("stream_addr", mem_addr, 32'h200 + 32'(4 * i));
      checkOutput("stream_data", mem_data, 32'hB000_0000 + 32'(i));
      tick();
      checkOutput("stream_ovf", 32'(overflow), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 8; i < 12; i++) begin
      checkOutput("stream_tail_addr", mem_addr, 32'h200 + 32'(4 * i));
      tick();
    end
    checkOutput("stream_empty", 32'(empty), 32'd1);

    $display("[TB] hazard detection");
    applyStimulus(1'b1, 32'h40, 32'h1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h44, 32'h2, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    hazard_addr = 32'h44;
    #1;
    checkOutput("hz_tail", 32'(hazard_hit), 32'd1);
    hazard_addr = 32'h40;
    #1;
    checkOutput("hz_head", 32'(hazard_hit), 32'd1);
    hazard_addr = 32'h48;
    applyStimulus(1'b1, 32'h48, 32'h3, 1'b0);
    checkOutput("hz_same_cycle_wr", 32'(hazard_hit), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    hazard_addr = 32'h44;
    #1;
    checkOutput("hz_popping", 32'(hazard_hit), 32'd1);
    tick();
    checkOutput("hz_stale", 32'(hazard_hit), 32'd0);
    checkOutput("hz_empty", 32'(empty), 32'd1);

    $display("[TB] overflow priority and mid-operation reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h400, 32'hEE, 1'b0);
    clear_overflow = 1'b1;
    tick();
    checkOutput("set_wins_ovf", 32'(overflow), 32'd1);
    checkOutput("set_wins_count", 32'(count), 32'd4);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    clear_overflow = 1'b0;
    checkOutput("clear_alone", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 32'h500, 32'h55, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("post_rst_addr", mem_addr, 32'h500);
    checkOutput("post_rst_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_write_buffer.md
Name: mat_write_buffer

Overview:
- Write-side buffer directly downstream of matrixProcessor.
- Captures matrixProcessor's single-cycle write strobes (writeEn/writeAddr/writeData) into an in-order FIFO.
- Drains the FIFO to the shared memory bus using a valid/ready handshake, so matrixProcessor never waits on memory for writes.
- Also flags read-after-write hazards against pending writes, so the read path can hold off until those writes are committed.

Parameters:
- WIDTH, 32, address and data width; matches matrixProcessor WIDTH.
- DEPTH, 8, number of FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_wr_en  input  1  write strobe from matrixProcessor writeEn.
- in_wr_addr  input  WIDTH  write address from matrixProcessor writeAddr.
- in_wr_data  input  WIDTH  write data from matrixProcessor writeData.
- hazard_addr  input  WIDTH  address currently being read (matrixProcessor readAddr).
- hazard_hit  output  1  hazard_addr matches the address of a pending entry.
- mem_valid  output  1  head entry presented to memory.
- mem_addr  output  WIDTH  head entry address.
- mem_data  output  WIDTH  head entry data.
- mem_ready  input  1  memory accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky flag: a write was dropped.
- clear_overflow  input  1  clears overflow.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values, applied at the next rising edge with rst=1:
  - read/write pointers = 0, count = 0
  - empty = 1, full = 0, mem_valid = 0, overflow = 0
  - entry storage contents are don't-care
  - mem_addr and mem_data are don't-care while mem_valid = 0
- Reset mid-operation discards all pending entries; no handshake completes in that cycle.
- Pop: occurs when mem_valid && mem_ready. The read pointer advances modulo DEPTH.
- Push: occurs when in_wr_en && (!full || pop). The entry is written at the write pointer, which advances modulo DEPTH.
- Simultaneous push and pop when full is legal: count stays DEPTH and nothing is dropped.
- Drop: in_wr_en && full && !pop. The write is discarded, all state except overflow is unchanged, and overflow is set to 1 on the next edge.
- overflow set/clear:
  - overflow clears on clear_overflow = 1.
  - If set and clear occur in the same cycle, set wins.
- count update: count_next = count + push − pop.
  - empty and full are derived from the registered count (combinational decode, no extra latency).
- Output timing:
  - mem_valid = !empty.
  - mem_addr and mem_data come from the entry at the read pointer (combinational read of registered storage).
  - Latency: a pushed entry is first visible on mem_valid/mem_addr/mem_data the cycle after the push. There is no input-to-output bypass, including when the FIFO is empty.
- Handshake rules:
  - While mem_valid = 1 and mem_ready = 0, mem_addr and mem_data hold stable.
  - mem_valid never deasserts without a pop.
  - Drain order is strictly FIFO.
  - mem_ready while mem_valid = 0 is ignored.
- Hazard detection:
  - hazard_hit is combinational: OR over all occupied entries of (entry_addr == hazard_addr).
  - Occupancy is determined by the pointers and count, not by stale storage.
  - The entry being popped in the current cycle still counts.
  - The same-cycle in_wr_addr does not count.
  - hazard_hit = 0 when empty.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; occupancy masking must be correct across the wrap.

Test Plan (DEPTH=4, WIDTH=32):
1. Reset then idle → count=0, empty=1, mem_valid=0, overflow=0, hazard_hit=0 for 10 cycles, regardless of mem_ready.
2. Push addr 0x100 / data 0xAAAA0001 with mem_ready=1 → mem_valid=1, mem_addr=0x100 on the next cycle only; popped that cycle; empty=1 the cycle after.
3. mem_ready=0, push 0x10, 0x14, 0x18, 0x1C → full=1, count=4. Then push 0x20 → dropped, overflow=1, count=4. Raise mem_ready → drains 0x10, 0x14, 0x18, 0x1C in order; 0x20 never appears.
4. At full with mem_ready=1 and in_wr_en=1 every cycle for 8 cycles → count stays 4, overflow stays 0, output order matches input order through pointer wrap.
5. Pending entries {0x40, 0x44}, hazard_addr=0x44 → hazard_hit=1. After both entries drain → hazard_hit=0. With a stale 0x44 left in storage at a freed slot → hazard_hit=0.
6. Assert clear_overflow together with a new drop → overflow stays 1. Then clear_overflow alone → overflow=0. Assert rst with 3 entries pending → count=0, mem_valid=0 the next cycle.
